// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: access-type codes and requester indices.
package dmem_pkg;

   localparam logic [2:0] MT_B  = 3'b000;
   localparam logic [2:0] MT_H  = 3'b001;
   localparam logic [2:0] MT_W  = 3'b010;
   localparam logic [2:0] MT_BU = 3'b100;
   localparam logic [2:0] MT_HU = 3'b101;

   localparam int unsigned REQ_CPU = 0;
   localparam int unsigned REQ_DMA = 1;
   localparam int unsigned NumReq  = 2;

   typedef logic [NumReq-1:0] gnt_vec_t;

   // True for the five access types the memory decodes; others still pass through the arbiter.
   function automatic logic mt_is_legal(logic [2:0] t);
      logic ok;
      case (t)
         MT_B, MT_H, MT_W, MT_BU, MT_HU: ok = 1'b1;
         default:                        ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port data memory.
interface dmem_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) ();

   logic              r0_req;
   logic              r0_we;
   logic [ADDR_W-1:0] r0_addr;
   logic [DATA_W-1:0] r0_wdata;
   logic [2:0]        r0_type;
   logic              r0_gnt;
   logic              r0_rvalid;
   logic [DATA_W-1:0] r0_rdata;

   logic              r1_req;
   logic              r1_we;
   logic [ADDR_W-1:0] r1_addr;
   logic [DATA_W-1:0] r1_wdata;
   logic [2:0]        r1_type;
   logic              r1_gnt;
   logic              r1_rvalid;
   logic [DATA_W-1:0] r1_rdata;

   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [2:0]        mem_type;
   logic              mem_we;
   logic [DATA_W-1:0] mem_rdata;

   logic [15:0]       conflict_cnt;

   // Requesters plus memory side.
   modport master (
      output r0_req, r0_we, r0_addr, r0_wdata, r0_type,
      input  r0_gnt, r0_rvalid, r0_rdata,
      output r1_req, r1_we, r1_addr, r1_wdata, r1_type,
      input  r1_gnt, r1_rvalid, r1_rdata,
      input  mem_addr, mem_wdata, mem_type, mem_we,
      output mem_rdata,
      input  conflict_cnt
   );

   // Arbiter side.
   modport slave (
      input  r0_req, r0_we, r0_addr, r0_wdata, r0_type,
      output r0_gnt, r0_rvalid, r0_rdata,
      input  r1_req, r1_we, r1_addr, r1_wdata, r1_type,
      output r1_gnt, r1_rvalid, r1_rdata,
      output mem_addr, mem_wdata, mem_type, mem_we,
      input  mem_rdata,
      output conflict_cnt
   );

endinterface

// File: rtl/arb_wait_ctr.sv
// Bounded-wait tracker for the DMA requester: after MAX_WAIT consecutive denied cycles the
// DMA port is forced to win its next request.
module arb_wait_ctr #(
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic r1_req_i,
   input  logic r1_gnt_i,
   output logic force1_o
);

   localparam logic [3:0] WaitLast = 4'(MAX_WAIT - 1);

   logic [3:0] wait_cnt_q, wait_cnt_d;
   logic       force1_q, force1_d;

   // Any cycle that is not a denied DMA request restarts the wait window.
   always_comb begin
      wait_cnt_d = '0;
      force1_d   = 1'b0;
      if (r1_req_i && !r1_gnt_i) begin
         wait_cnt_d = (wait_cnt_q == 4'hF) ? wait_cnt_q : wait_cnt_q + 4'd1;
         force1_d   = force1_q || (wait_cnt_q == WaitLast);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wait_cnt_q <= '0;
         force1_q   <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         force1_q   <= force1_d;
      end
   end

   assign force1_o = force1_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of the single-port data memory (CPU = r0, DMA = r1).
// Define DMEM_ARB_STATS_EN to build the 16-bit saturating conflict counter.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned MAX_WAIT = 4
) (
   input logic           clk,
   input logic           rst,
   dmem_arbiter_if.slave bus_io
);

   gnt_vec_t          gnt;
   logic              force1;

   logic              r0_rvalid_q, r0_rvalid_d;
   logic              r1_rvalid_q, r1_rvalid_d;
   logic [DATA_W-1:0] r0_rdata_q, r0_rdata_d;
   logic [DATA_W-1:0] r1_rdata_q, r1_rdata_d;

   arb_wait_ctr #(
      .MAX_WAIT (MAX_WAIT)
   ) u_wait_ctr (
      .clk_i    (clk),
      .rst_i    (rst),
      .r1_req_i (bus_io.r1_req),
      .r1_gnt_i (gnt[REQ_DMA]),
      .force1_o (force1)
   );

   // CPU has priority unless the DMA port has exhausted its wait budget.
   always_comb begin
      gnt = '0;
      if (!rst) begin
         if (bus_io.r1_req && (force1 || !bus_io.r0_req)) begin
            gnt[REQ_DMA] = 1'b1;
         end else if (bus_io.r0_req) begin
            gnt[REQ_CPU] = 1'b1;
         end
      end
   end

   assign bus_io.r0_gnt = gnt[REQ_CPU];
   assign bus_io.r1_gnt = gnt[REQ_DMA];

   always_comb begin
      bus_io.mem_addr  = '0;
      bus_io.mem_wdata = '0;
      bus_io.mem_type  = '0;
      bus_io.mem_we    = 1'b0;
      unique case (gnt)
         2'b01: begin
            bus_io.mem_addr  = bus_io.r0_addr;
            bus_io.mem_wdata = bus_io.r0_wdata;
            bus_io.mem_type  = bus_io.r0_type;
            bus_io.mem_we    = bus_io.r0_we;
         end
         2'b10: begin
            bus_io.mem_addr  = bus_io.r1_addr;
            bus_io.mem_wdata = bus_io.r1_wdata;
            bus_io.mem_type  = bus_io.r1_type;
            bus_io.mem_we    = bus_io.r1_we;
         end
         default: ;
      endcase
   end

   always_comb begin
      r0_rvalid_d = gnt[REQ_CPU] && !bus_io.r0_we;
      r1_rvalid_d = gnt[REQ_DMA] && !bus_io.r1_we;
      r0_rdata_d  = r0_rvalid_d ? bus_io.mem_rdata : r0_rdata_q;
      r1_rdata_d  = r1_rvalid_d ? bus_io.mem_rdata : r1_rdata_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r0_rvalid_q <= 1'b0;
         r1_rvalid_q <= 1'b0;
         r0_rdata_q  <= '0;
         r1_rdata_q  <= '0;
      end else begin
         r0_rvalid_q <= r0_rvalid_d;
         r1_rvalid_q <= r1_rvalid_d;
         r0_rdata_q  <= r0_rdata_d;
         r1_rdata_q  <= r1_rdata_d;
      end
   end

   assign bus_io.r0_rvalid = r0_rvalid_q;
   assign bus_io.r1_rvalid = r1_rvalid_q;
   assign bus_io.r0_rdata  = r0_rdata_q;
   assign bus_io.r1_rdata  = r1_rdata_q;

`ifdef DMEM_ARB_STATS_EN
   logic [15:0] conflict_q, conflict_d;

   // Counts raw request overlap, independent of which side wins.
   always_comb begin
      conflict_d = conflict_q;
      if (bus_io.r0_req && bus_io.r1_req && (conflict_q != 16'hFFFF)) begin
         conflict_d = conflict_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         conflict_q <= '0;
      end else begin
         conflict_q <= conflict_d;
      end
   end

   assign bus_io.conflict_cnt = conflict_q;
`else
   assign bus_io.conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a simple word-wide memory model.
module tb_dmem_arbiter;
   import dmem_pkg::*;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;

   dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   dmem_arbiter #(
      .ADDR_W   (AW),
      .DATA_W   (DW),
      .MAX_WAIT (4)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus)
   );

   // Word-wide memory: legal types read/write the full word, illegal types read 0 and never write.
   logic [31:0] mem [0:63];
   always_comb bus.mem_rdata = mt_is_legal(bus.mem_type) ? mem[bus.mem_addr[7:2]] : 32'h0;
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      end else if (bus.mem_we && mt_is_legal(bus.mem_type)) begin
         mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_r0(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] typ);
      bus.r0_req = req; bus.r0_we = we; bus.r0_addr = addr;
      bus.r0_wdata = wdata; bus.r0_type = typ;
   endtask

   task automatic set_r1(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] typ);
      bus.r1_req = req; bus.r1_we = we; bus.r1_addr = addr;
      bus.r1_wdata = wdata; bus.r1_type = typ;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_r0(1'b1, 1'b1, 32'h10, 32'h1111_1111, MT_W);
      set_r1(1'b1, 1'b1, 32'h20, 32'h2222_2222, MT_W);
      @(negedge clk);
      n_cmp++; if (bus.r0_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_r0_gnt: got %b want 0", bus.r0_gnt); end
      n_cmp++; if (bus.r1_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_r1_gnt: got %b want 0", bus.r1_gnt); end
      n_cmp++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we: got %b want 0", bus.mem_we); end
      tick(); tick();
      n_cmp++; if (bus.r0_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_r0_rvalid: got %b want 0", bus.r0_rvalid); end
      n_cmp++; if (bus.r1_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_r1_rvalid: got %b want 0", bus.r1_rvalid); end
      n_cmp++; if (bus.r0_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_r0_rdata: got %h want 0", bus.r0_rdata); end
      n_cmp++; if (bus.r1_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_r1_rdata: got %h want 0", bus.r1_rdata); end
      n_cmp++; if (bus.conflict_cnt !== 16'h0) begin n_fail++; $display("FAIL rst_conflict: got %h want 0", bus.conflict_cnt); end
      rst = 1'b0;
      bus.r0_req = 1'b0;
      bus.r1_req = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL idle_addr: got %h want 0", bus.mem_addr); end
      n_cmp++; if (bus.mem_wdata !== 32'h0) begin n_fail++; $display("FAIL idle_wdata: got %h want 0", bus.mem_wdata); end
      n_cmp++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL idle_we: got %b want 0", bus.mem_we); end
      tick();
   endtask

   task automatic test_cpu_store();
      set_r0(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, MT_W);
      @(negedge clk);
      n_cmp++; if (bus.r0_gnt !== 1'b1) begin n_fail++; $display("FAIL st0_gnt: got %b want 1", bus.r0_gnt); end
      n_cmp++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL st0_mem_we: got %b want 1", bus.mem_we); end
      n_cmp++; if (bus.mem_addr !== 32'h10) begin n_fail++; $display("FAIL st0_addr: got %h want 10", bus.mem_addr); end
      n_cmp++; if (bus.mem_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL st0_wdata: got %h want deadbeef", bus.mem_wdata); end
      tick();
      bus.r0_req = 1'b0;
      n_cmp++; if (bus.r0_rvalid !== 1'b0) begin n_fail++; $display("FAIL st0_rvalid: got %b want 0", bus.r0_rvalid); end
   endtask

   task automatic test_single_load();
      set_r0(1'b1, 1'b0, 32'h10, 32'h0, MT_W);
      @(negedge clk);
      n_cmp++; if (bus.r0_gnt !== 1'b1) begin n_fail++; $display("FAIL ld0_gnt: got %b want 1", bus.r0_gnt); end
      n_cmp++; if (bus.r1_gnt !== 1'b0) begin n_fail++; $display("FAIL ld0_r1_gnt: got %b want 0", bus.r1_gnt); end
      n_cmp++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL ld0_mem_we: got %b want 0", bus.mem_we); end
      tick();
      bus.r0_req = 1'b0;
      n_cmp++; if (bus.r0_rvalid !== 1'b1) begin n_fail++; $display("FAIL ld0_rvalid: got %b want 1", bus.r0_rvalid); end
      n_cmp++; if (bus.r0_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ld0_rdata: got %h want deadbeef", bus.r0_rdata); end
      n_cmp++; if (bus.r1_rvalid !== 1'b0) begin n_fail++; $display("FAIL ld0_r1_rvalid: got %b want 0", bus.r1_rvalid); end
      n_cmp++; if (bus.r1_rdata !== 32'h0) begin n_fail++; $display("FAIL ld0_r1_rdata: got %h want 0", bus.r1_rdata); end
      tick();
      n_cmp++; if (bus.r0_rvalid !== 1'b0) begin n_fail++; $display("FAIL ld0_pulse: got %b want 0", bus.r0_rvalid); end
      n_cmp++; if (bus.r0_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ld0_hold: got %h want deadbeef", bus.r0_rdata); end
   endtask

   task automatic test_dma_store_load();
      set_r1(1'b1, 1'b1, 32'h20, 32'h0000_00AB, MT_B);
      @(negedge clk);
      n_cmp++; if (bus.r1_gnt !== 1'b1) begin n_fail++; $display("FAIL st1_gnt: got %b want 1", bus.r1_gnt); end
      n_cmp++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL st1_mem_we: got %b want 1", bus.mem_we); end
      n_cmp++; if (bus.mem_addr !== 32'h20) begin n_fail++; $display("FAIL st1_addr: got %h want 20", bus.mem_addr); end
      tick();
      bus.r1_we = 1'b0;
      n_cmp++; if (bus.r1_rvalid !== 1'b0) begin n_fail++; $display("FAIL st1_rvalid: got %b want 0", bus.r1_rvalid); end
      @(negedge clk);
      n_cmp++; if (bus.r1_gnt !== 1'b1) begin n_fail++; $display("FAIL ld1_gnt: got %b want 1", bus.r1_gnt); end
      n_cmp++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL ld1_mem_we: got %b want 0", bus.mem_we); end
      tick();
      bus.r1_req = 1'b0;
      n_cmp++; if (bus.r1_rvalid !== 1'b1) begin n_fail++; $display("FAIL ld1_rvalid: got %b want 1", bus.r1_rvalid); end
      n_cmp++; if (bus.r1_rdata !== 32'h0000_00AB) begin n_fail++; $display("FAIL ld1_rdata: got %h want 000000ab", bus.r1_rdata); end
      n_cmp++; if (bus.r0_rvalid !== 1'b0) begin n_fail++; $display("FAIL ld1_r0_rvalid: got %b want 0", bus.r0_rvalid); end
      n_cmp++; if (bus.r0_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ld1_r0_hold: got %h want deadbeef", bus.r0_rdata); end
      tick();
   endtask

   task automatic test_back_to_back();
      set_r0(1'b1, 1'b0, 32'h20, 32'h0, MT_W);
      @(negedge clk);
      n_cmp++; if (bus.r0_gnt !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt0: got %b want 1", bus.r0_gnt); end
      tick();
      bus.r0_addr = 32'h10;
      n_cmp++; if (bus.r0_rdata !== 32'h0000_00AB) begin n_fail++; $display("FAIL b2b_rdata0: got %h want 000000ab", bus.r0_rdata); end
      @(negedge clk);
      n_cmp++; if (bus.r0_gnt !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt1: got %b want 1", bus.r0_gnt); end
      tick();
      bus.r0_req = 1'b0;
      n_cmp++; if (bus.r0_rvalid !== 1'b1) begin n_fail++; $display("FAIL b2b_rvalid1: got %b want 1", bus.r0_rvalid); end
      n_cmp++; if (bus.r0_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL b2b_rdata1: got %h want deadbeef", bus.r0_rdata); end
      tick();
      n_cmp++; if (bus.r0_rvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b want 0", bus.r0_rvalid); end
   endtask

   task automatic test_starvation();
      logic exp1;
      set_r0(1'b1, 1'b0, 32'h10, 32'h0, MT_W);
      set_r1(1'b1, 1'b0, 32'h20, 32'h0, MT_W);
      for (int i = 0; i < 10; i++) begin
         exp1 = ((i % 5) == 4);
         @(negedge clk);
         n_cmp++; if (bus.r1_gnt !== exp1) begin n_fail++; $display("FAIL starve_r1_gnt[%0d]: got %b want %b", i, bus.r1_gnt, exp1); end
         n_cmp++; if (bus.r0_gnt !== !exp1) begin n_fail++; $display("FAIL starve_r0_gnt[%0d]: got %b want %b", i, bus.r0_gnt, !exp1); end
         tick();
         n_cmp++; if (bus.r1_rvalid !== exp1) begin n_fail++; $display("FAIL starve_r1_rvalid[%0d]: got %b want %b", i, bus.r1_rvalid, exp1); end
         n_cmp++; if (bus.r0_rvalid !== !exp1) begin n_fail++; $display("FAIL starve_r0_rvalid[%0d]: got %b want %b", i, bus.r0_rvalid, !exp1); end
`ifdef DMEM_ARB_STATS_EN
         if (i == 4) begin
            n_cmp++; if (bus.conflict_cnt !== 16'd5) begin n_fail++; $display("FAIL starve_conflict: got %0d want 5", bus.conflict_cnt); end
         end
`endif
      end
      n_cmp++; if (bus.r1_rdata !== 32'h0000_00AB) begin n_fail++; $display("FAIL starve_r1_rdata: got %h want 000000ab", bus.r1_rdata); end
   endtask

   task automatic test_withdraw();
      logic [7:0] r1_pat;
      logic [7:0] gnt_pat;
      r1_pat  = 8'hFB;
      gnt_pat = 8'h80;
      for (int i = 0; i < 8; i++) begin
         bus.r1_req = r1_pat[i];
         @(negedge clk);
         n_cmp++; if (bus.r1_gnt !== gnt_pat[i]) begin n_fail++; $display("FAIL wd_r1_gnt[%0d]: got %b want %b", i, bus.r1_gnt, gnt_pat[i]); end
         n_cmp++; if (bus.r0_gnt !== !gnt_pat[i]) begin n_fail++; $display("FAIL wd_r0_gnt[%0d]: got %b want %b", i, bus.r0_gnt, !gnt_pat[i]); end
         tick();
      end
`ifdef DMEM_ARB_STATS_EN
      n_cmp++; if (bus.conflict_cnt !== 16'd17) begin n_fail++; $display("FAIL wd_conflict: got %0d want 17", bus.conflict_cnt); end
`else
      n_cmp++; if (bus.conflict_cnt !== 16'd0) begin n_fail++; $display("FAIL wd_conflict: got %0d want 0", bus.conflict_cnt); end
`endif
      bus.r0_req = 1'b0;
      bus.r1_req = 1'b0;
      tick();
   endtask

   task automatic test_illegal_type();
      set_r0(1'b1, 1'b0, 32'h10, 32'h0, 3'b110);
      @(negedge clk);
      n_cmp++; if (bus.r0_gnt !== 1'b1) begin n_fail++; $display("FAIL ill_gnt: got %b want 1", bus.r0_gnt); end
      n_cmp++; if (bus.mem_type !== 3'b110) begin n_fail++; $display("FAIL ill_type: got %b want 110", bus.mem_type); end
      tick();
      bus.r0_req = 1'b0;
      n_cmp++; if (bus.r0_rvalid !== 1'b1) begin n_fail++; $display("FAIL ill_rvalid: got %b want 1", bus.r0_rvalid); end
      n_cmp++; if (bus.r0_rdata !== 32'h0) begin n_fail++; $display("FAIL ill_rdata: got %h want 0", bus.r0_rdata); end
      set_r1(1'b1, 1'b1, 32'h20, 32'h55, 3'b111);
      @(negedge clk);
      n_cmp++; if (bus.r1_gnt !== 1'b1) begin n_fail++; $display("FAIL ill_st_gnt: got %b want 1", bus.r1_gnt); end
      n_cmp++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL ill_st_we: got %b want 1", bus.mem_we); end
      n_cmp++; if (bus.mem_type !== 3'b111) begin n_fail++; $display("FAIL ill_st_type: got %b want 111", bus.mem_type); end
      tick();
      bus.r1_req = 1'b0;
   endtask

   task automatic test_reset_mid();
      set_r0(1'b1, 1'b0, 32'h10, 32'h0, MT_W);
      @(negedge clk);
      n_cmp++; if (bus.r0_gnt !== 1'b1) begin n_fail++; $display("FAIL rm_gnt: got %b want 1", bus.r0_gnt); end
      tick();
      n_cmp++; if (bus.r0_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rm_pre_rdata: got %h want deadbeef", bus.r0_rdata); end
      rst = 1'b1;
      bus.r0_req = 1'b0;
      set_r1(1'b1, 1'b1, 32'h20, 32'h77, MT_W);
      @(negedge clk);
      n_cmp++; if (bus.r0_gnt !== 1'b0) begin n_fail++; $display("FAIL rm_r0_gnt: got %b want 0", bus.r0_gnt); end
      n_cmp++; if (bus.r1_gnt !== 1'b0) begin n_fail++; $display("FAIL rm_r1_gnt: got %b want 0", bus.r1_gnt); end
      n_cmp++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL rm_mem_we: got %b want 0", bus.mem_we); end
      tick();
      n_cmp++; if (bus.r0_rvalid !== 1'b0) begin n_fail++; $display("FAIL rm_rvalid: got %b want 0", bus.r0_rvalid); end
      n_cmp++; if (bus.r0_rdata !== 32'h0) begin n_fail++; $display("FAIL rm_rdata: got %h want 0", bus.r0_rdata); end
      n_cmp++; if (bus.conflict_cnt !== 16'h0) begin n_fail++; $display("FAIL rm_conflict: got %h want 0", bus.conflict_cnt); end
      rst = 1'b0;
      bus.r1_req = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_cpu_store();
      test_single_load();
      test_dma_store_load();
      test_back_to_back();
      test_starvation();
      test_withdraw();
      test_illegal_type();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter/sequencer in front of the single-port data memory.
- Requester 0 is the CPU load/store unit; requester 1 is the DMA/program-loader port.
- Grants at most one access per cycle, drives the memory port, and returns registered read data to the winner one cycle later.
- Prevents DMA starvation with a bounded-wait counter.

Parameters:
- ADDR_W, 32, address width passed through to memory (memory applies its own index mapping).
- DATA_W, 32, data width.
- MAX_WAIT, 4, consecutive denied cycles for r1 before r1 is forced to win; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- r0_req  in  1  CPU request; hold with payload stable until r0_gnt
- r0_we  in  1  1=store, 0=load
- r0_addr  in  ADDR_W  byte address (signed interpretation left to memory)
- r0_wdata  in  DATA_W  store data
- r0_type  in  3  access type: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- r0_gnt  out  1  combinational grant, same cycle as access
- r0_rvalid  out  1  registered pulse, load data valid
- r0_rdata  out  DATA_W  registered load data
- r1_req, r1_we, r1_addr, r1_wdata, r1_type, r1_gnt, r1_rvalid, r1_rdata: same as r0 for the DMA port
- mem_addr  out  ADDR_W  to memory address
- mem_wdata  out  DATA_W  to memory write data
- mem_type  out  3  to memory load/store type
- mem_we  out  1  to memory write enable
- mem_rdata  in  DATA_W  combinational read data from memory
- conflict_cnt  out  16  statistics, see Optional Feature

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: r0/r1_rvalid=0, r0/r1_rdata=0, wait_cnt=0, force1=0. While rst=1, both gnt=0 and mem_we=0.
- Grant logic (combinational from req and registered state):
  - force1=1 and r1_req: r1 wins.
  - Otherwise r0_req: r0 wins.
  - Otherwise r1_req: r1 wins.
  - Never both gnt=1.
- Memory mux:
  - Winner's addr/wdata/type/we drive mem_*.
  - With no grant: mem_we=0, mem_addr/wdata/type=0.
  - Writes commit at the memory's clock edge in the grant cycle; no write acknowledge beyond gnt.
- Reads (latency 1):
  - On the grant cycle with we=0, mem_rdata is captured into the winner's rdata register.
  - The winner's rvalid=1 for exactly the next cycle.
  - The non-winner's rdata holds its value.
  - rvalid=0 in every other cycle.
- Starvation counter:
  - When r1_req=1 and r1 is not granted: wait_cnt increments.
  - When wait_cnt reaches MAX_WAIT-1 on a denied cycle: force1 is set for the next cycle.
  - On an r1 grant, or when r1_req=0: wait_cnt and force1 clear.
- Back-to-back: a requester may keep req high after gnt for the next access; a new grant is possible every cycle.
- Request withdrawal: dropping req before gnt is legal and performs no access; wait_cnt clears if r1 withdraws.
- Illegal type (011, 110, 111): granted and passed through unchanged. A load still produces an rvalid pulse with whatever memory returns.
- Reset mid-operation: a pending rvalid is squashed (0 in the cycle after rst), and rdata clears.

Optional Feature:
- Macro DMEM_ARB_STATS_EN.
- Defined: conflict_cnt counts cycles with r0_req and r1_req both high. It is 16 bits, saturates at 0xFFFF, and clears on rst.
- Undefined: the conflict_cnt port remains and is tied to 0; no counter logic is instantiated.

Decomposition:
- Shared package dmem_pkg:
  - access-type constants MT_B=3'b000, MT_H=3'b001, MT_W=3'b010, MT_BU=3'b100, MT_HU=3'b101;
  - requester index constants REQ_CPU=0, REQ_DMA=1.
- Sub-module arb_wait_ctr: wait_cnt/force1 logic, parameterised by MAX_WAIT.

Test Plan:
- Single r0 load at 0x10 holding 0xDEADBEEF, type 010 -> r0_gnt same cycle, r0_rvalid=1 with r0_rdata=0xDEADBEEF next cycle, r1 outputs unchanged.
- r1 store 0x000000AB to 0x20 type 000, then r1 load type 000 -> second load returns 0x000000AB; mem_we=1 only in the store cycle.
- r0_req and r1_req held high continuously, MAX_WAIT=4 -> grants r0,r0,r0,r0,r1 repeating. conflict_cnt=5 after 5 cycles (with DMEM_ARB_STATS_EN).
- r1_req high 2 cycles while r0 busy, then dropped, then reasserted -> wait_cnt restarts from 0; r1 is not forced until 4 further denied cycles.
- rst asserted in the cycle after r0 load grant -> r0_rvalid=0, r0_rdata=0 in the following cycle, no gnt during rst.
- r0 load with type 110 -> r0_gnt=1, r0_rvalid=1 next cycle, r0_rdata=0.
